// File: rtl/score_keeper.sv
// Match controller for the score display: counts points from goal misses and
// sequences idle -> serve -> play -> game-over, releasing the ball after a frame delay.
module score_keeper #(
  parameter int WIN_SCORE   = 9,
  parameter int SERVE_DELAY = 60,
  parameter int DLY_W       = 6
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic       start,
  input  logic       miss_p1,
  input  logic       miss_p2,
  output logic [3:0] score_p1,
  output logic [3:0] score_p2,
  output logic       serve,
  output logic       serve_dir,
  output logic       playing,
  output logic       game_over
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SERVE     = 2'd1,
    PLAY      = 2'd2,
    GAME_OVER = 2'd3
  } state_t;

  localparam logic [3:0]       WIN_S    = 4'(WIN_SCORE);
  localparam logic [DLY_W-1:0] CNT_LAST = DLY_W'(SERVE_DELAY - 1);

  state_t           state, state_n;
  logic [3:0]       score_p1_n, score_p2_n;
  logic             serve_n, serve_dir_n;
  logic [DLY_W-1:0] cnt, cnt_n;
  logic             start_q;
  logic             start_rise;

  // Saturating point add: the winning score is the ceiling, never wraps.
  function automatic logic [3:0] sat_inc(input logic [3:0] s);
    return (s >= WIN_S) ? WIN_S : s + 4'd1;
  endfunction

  assign start_rise = start & ~start_q;

  always_comb begin
    state_n     = state;
    score_p1_n  = score_p1;
    score_p2_n  = score_p2;
    serve_n     = 1'b0;
    serve_dir_n = serve_dir;
    cnt_n       = cnt;
    unique case (state)
      IDLE: begin
        if (start_rise) begin
          score_p1_n = 4'd0;
          score_p2_n = 4'd0;
          cnt_n      = '0;
          state_n    = SERVE;
        end
      end
      SERVE: begin
        if (frame_tick) begin
          if (cnt == CNT_LAST) begin
            serve_n = 1'b1;
            cnt_n   = '0;
            state_n = PLAY;
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
      end
      PLAY: begin
        // A coincident frame_tick is dropped: the delay restarts from zero.
        if (miss_p1 && !miss_p2) begin
          score_p2_n  = sat_inc(score_p2);
          serve_dir_n = 1'b0;
          cnt_n       = '0;
          state_n     = (sat_inc(score_p2) == WIN_S) ? GAME_OVER : SERVE;
        end else if (miss_p2 && !miss_p1) begin
          score_p1_n  = sat_inc(score_p1);
          serve_dir_n = 1'b1;
          cnt_n       = '0;
          state_n     = (sat_inc(score_p1) == WIN_S) ? GAME_OVER : SERVE;
        end else if (miss_p1 && miss_p2) begin
          cnt_n   = '0;
          state_n = SERVE;
        end
      end
      GAME_OVER: begin
        if (start_rise) begin
          score_p1_n  = 4'd0;
          score_p2_n  = 4'd0;
          serve_dir_n = 1'b1;
          cnt_n       = '0;
          state_n     = SERVE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      score_p1  <= 4'd0;
      score_p2  <= 4'd0;
      serve     <= 1'b0;
      serve_dir <= 1'b1;
      cnt       <= '0;
      start_q   <= 1'b0;
    end else begin
      state     <= state_n;
      score_p1  <= score_p1_n;
      score_p2  <= score_p2_n;
      serve     <= serve_n;
      serve_dir <= serve_dir_n;
      cnt       <= cnt_n;
      start_q   <= start;
    end
  end

  assign playing   = (state == PLAY);
  assign game_over = (state == GAME_OVER);

endmodule

// File: tb/tb_score_keeper.sv
// Directed bench for score_keeper with a three-tick serve delay.
module tb_score_keeper;

  logic       clk = 1'b0;
  logic       reset;
  logic       frame_tick, start, miss_p1, miss_p2;
  logic [3:0] score_p1, score_p2;
  logic       serve, serve_dir, playing, game_over;

  int total  = 0;
  int passed = 0;

  score_keeper #(.WIN_SCORE(9), .SERVE_DELAY(3), .DLY_W(6)) dut (
    .clk        (clk),
    .reset      (reset),
    .frame_tick (frame_tick),
    .start      (start),
    .miss_p1    (miss_p1),
    .miss_p2    (miss_p2),
    .score_p1   (score_p1),
    .score_p2   (score_p2),
    .serve      (serve),
    .serve_dir  (serve_dir),
    .playing    (playing),
    .game_over  (game_over)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
  endtask

  // One clock: pulses driven on the falling edge, outputs observed 1 time unit after rising edge.
  task automatic cyc(input logic ft, input logic m1, input logic m2);
    @(negedge clk);
    frame_tick = ft;
    miss_p1    = m1;
    miss_p2    = m2;
    @(posedge clk);
    #1;
  endtask

  task automatic serve_seq(input string tag);
    cyc(1, 0, 0);
    check({tag, "_t1_serve"}, serve, 0);
    cyc(1, 0, 0);
    check({tag, "_t2_serve"}, serve, 0);
    cyc(1, 0, 0);
    check({tag, "_t3_serve"}, serve, 1);
    check({tag, "_t3_playing"}, playing, 1);
    cyc(0, 0, 0);
    check({tag, "_after_serve"}, serve, 0);
    check({tag, "_after_playing"}, playing, 1);
  endtask

  initial begin
    reset = 1'b1; frame_tick = 0; start = 0; miss_p1 = 0; miss_p2 = 0;
    #12;
    check("rst_score_p1", score_p1, 0);
    check("rst_score_p2", score_p2, 0);
    check("rst_serve", serve, 0);
    check("rst_serve_dir", serve_dir, 1);
    check("rst_playing", playing, 0);
    check("rst_game_over", game_over, 0);
    @(negedge clk);
    reset = 1'b0;
    cyc(1, 0, 0);
    check("idle_no_serve", serve, 0);
    check("idle_playing", playing, 0);

    // 1: start, three ticks, serve
    start = 1'b1;
    cyc(0, 0, 0);
    check("t1_serve_state_playing", playing, 0);
    serve_seq("t1");
    check("t1_score_p1", score_p1, 0);
    check("t1_score_p2", score_p2, 0);
    check("t1_serve_dir", serve_dir, 1);

    // 2: P2 misses, point to P1
    cyc(0, 0, 1);
    check("t2_score_p1", score_p1, 1);
    check("t2_serve_dir", serve_dir, 1);
    check("t2_playing", playing, 0);
    serve_seq("t2");

    // 3: both miss with a coincident tick; tick must not count
    cyc(1, 1, 1);
    check("t3_score_p1", score_p1, 1);
    check("t3_score_p2", score_p2, 0);
    check("t3_serve_dir", serve_dir, 1);
    check("t3_playing", playing, 0);
    serve_seq("t3");

    // P1 misses: point to P2, serve toward P1
    cyc(0, 1, 0);
    check("p1miss_score_p2", score_p2, 1);
    check("p1miss_serve_dir", serve_dir, 0);
    serve_seq("p1miss");

    // 4: run P1 up to the winning score
    for (int i = 2; i <= 9; i++) begin
      cyc(0, 0, 1);
      check($sformatf("t4_score_p1_%0d", i), score_p1, 32'(i));
      if (i < 9) serve_seq($sformatf("t4_%0d", i));
    end
    check("t4_game_over", game_over, 1);
    check("t4_playing", playing, 0);
    cyc(1, 1, 0);
    cyc(1, 0, 1);
    cyc(1, 1, 1);
    check("t4_held_score_p1", score_p1, 9);
    check("t4_held_score_p2", score_p2, 1);
    check("t4_held_serve", serve, 0);
    cyc(1, 0, 0);
    check("t4_held_start_no_restart", game_over, 1);
    check("t4_held_serve2", serve, 0);

    // 5: new start edge restarts the match
    start = 1'b0;
    cyc(0, 0, 0);
    check("t5_still_over", game_over, 1);
    start = 1'b1;
    cyc(0, 0, 0);
    check("t5_score_p1", score_p1, 0);
    check("t5_score_p2", score_p2, 0);
    check("t5_game_over", game_over, 0);
    check("t5_serve_dir", serve_dir, 1);
    serve_seq("t5");

    // 6: reset in SERVE with count at 2
    cyc(0, 1, 0);
    check("t6_score_p2", score_p2, 1);
    check("t6_serve_dir", serve_dir, 0);
    cyc(1, 0, 0);
    cyc(1, 0, 0);
    check("t6_pre_serve", serve, 0);
    @(negedge clk);
    start = 1'b0;
    frame_tick = 1'b1;
    #2;
    reset = 1'b1;
    #1;
    check("t6_async_score_p2", score_p2, 0);
    check("t6_async_serve_dir", serve_dir, 1);
    check("t6_async_playing", playing, 0);
    check("t6_async_serve", serve, 0);
    @(posedge clk);
    #1;
    check("t6_reset_edge_serve", serve, 0);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cyc(1, 0, 0);
      check($sformatf("t6_idle_serve_%0d", i), serve, 0);
      check($sformatf("t6_idle_playing_%0d", i), playing, 0);
    end
    start = 1'b1;
    cyc(0, 0, 0);
    serve_seq("t6_restart");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
